// File: rtl/tx_sched_pkg.sv
// Shared definitions for the transmit response scheduler: FSM states, source IDs, default widths.
package tx_sched_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ALU_WIDTH_DEF  = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_B0 = 3'd1,
        WAIT_B0 = 3'd2,
        SEND_B1 = 3'd3,
        WAIT_B1 = 3'd4
    } state_t;

    typedef enum logic {
        SRC_RF  = 1'b0,
        SRC_ALU = 1'b1
    } src_t;

endpackage

// File: rtl/result_capture_slot.sv
// One-entry capture slot: loads on a rising valid edge when empty, flags a drop when full.
module result_capture_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             clear_i,
    output logic             full_o,
    output logic             full_c_o,
    output logic [WIDTH-1:0] data_o,
    output logic             drop_c_o
);

    logic             prev_q;
    logic             full_q;
    logic             full_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             load_c;

    // A load in the same cycle as a clear takes the slot over with the new data.
    always_comb begin
        load_c   = valid_i & ~prev_q;
        full_d   = full_q;
        data_d   = data_q;
        drop_c_o = 1'b0;
        if (load_c && (!full_q || clear_i)) begin
            full_d = 1'b1;
            data_d = data_i;
        end else begin
            if (load_c) begin
                drop_c_o = 1'b1;
            end
            if (clear_i) begin
                full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_q <= 1'b0;
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            prev_q <= valid_i;
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o   = full_q;
    assign full_c_o = full_d;
    assign data_o   = data_q;

endmodule

// File: rtl/tx_response_scheduler.sv
// Arbitrates register-file and ALU results and serializes them byte-wise to the UART TX.
module tx_response_scheduler
    import tx_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ALU_WIDTH  = ALU_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RdData_Valid,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  ALU_OUT_Valid,
    input  logic [ALU_WIDTH-1:0]  ALU_OUT,
    input  logic                  TX_Busy,
    output logic [DATA_WIDTH-1:0] TX_P_Data,
    output logic                  TX_Data_Valid,
    output logic                  Sched_Busy,
    output logic                  Drop_Pulse
);

    logic                  rf_full, rf_full_c, rf_drop_c, rf_clr_c;
    logic                  alu_full, alu_full_c, alu_drop_c, alu_clr_c;
    logic [DATA_WIDTH-1:0] rf_data;
    logic [ALU_WIDTH-1:0]  alu_data;
    logic                  idle_next_c;
    src_t                  pick_c;

    state_t                state_q;
    src_t                  src_q;
    src_t                  last_q;
    logic                  armed_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_valid_q;
    logic                  busy_q;
    logic                  drop_q;

    result_capture_slot #(.WIDTH(DATA_WIDTH)) u_rf_slot (
        .CLK      (CLK),
        .RST      (RST),
        .valid_i  (RdData_Valid),
        .data_i   (RdData),
        .clear_i  (rf_clr_c),
        .full_o   (rf_full),
        .full_c_o (rf_full_c),
        .data_o   (rf_data),
        .drop_c_o (rf_drop_c)
    );

    result_capture_slot #(.WIDTH(ALU_WIDTH)) u_alu_slot (
        .CLK      (CLK),
        .RST      (RST),
        .valid_i  (ALU_OUT_Valid),
        .data_i   (ALU_OUT),
        .clear_i  (alu_clr_c),
        .full_o   (alu_full),
        .full_c_o (alu_full_c),
        .data_o   (alu_data),
        .drop_c_o (alu_drop_c)
    );

    assign rf_clr_c    = (state_q == WAIT_B0) && (src_q == SRC_RF) && !TX_Busy;
    assign alu_clr_c   = (state_q == WAIT_B1) && !TX_Busy;
    assign idle_next_c = ((state_q == IDLE) && !(rf_full || alu_full)) || rf_clr_c || alu_clr_c;

    // Round-robin only matters when both slots compete; last_q tracks the contested winner.
    assign pick_c = (rf_full && alu_full) ? ((last_q == SRC_ALU) ? SRC_RF : SRC_ALU)
                                          : (rf_full ? SRC_RF : SRC_ALU);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            src_q      <= SRC_RF;
            last_q     <= SRC_ALU;
            armed_q    <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            drop_q <= rf_drop_c | alu_drop_c;
            busy_q <= rf_full_c | alu_full_c | !idle_next_c;
            // armed_q: TX_Busy seen low since entering SEND, so a high level is a fresh accept.
            case (state_q)
                IDLE: begin
                    if (rf_full || alu_full) begin
                        src_q      <= pick_c;
                        state_q    <= SEND_B0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= (pick_c == SRC_RF) ? rf_data : alu_data[DATA_WIDTH-1:0];
                        armed_q    <= !TX_Busy;
                        if (rf_full && alu_full) begin
                            last_q <= pick_c;
                        end
                    end
                end
                SEND_B0: begin
                    if (TX_Busy && armed_q) begin
                        state_q    <= WAIT_B0;
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= '0;
                    end else if (!TX_Busy) begin
                        armed_q <= 1'b1;
                    end
                end
                WAIT_B0: begin
                    if (!TX_Busy) begin
                        if (src_q == SRC_RF) begin
                            state_q <= IDLE;
                        end else begin
                            state_q    <= SEND_B1;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= alu_data[ALU_WIDTH-1:DATA_WIDTH];
                            armed_q    <= 1'b1;
                        end
                    end
                end
                SEND_B1: begin
                    if (TX_Busy && armed_q) begin
                        state_q    <= WAIT_B1;
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= '0;
                    end else if (!TX_Busy) begin
                        armed_q <= 1'b1;
                    end
                end
                WAIT_B1: begin
                    if (!TX_Busy) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    tx_valid_q <= 1'b0;
                    tx_data_q  <= '0;
                end
            endcase
        end
    end

    assign TX_P_Data     = tx_data_q;
    assign TX_Data_Valid = tx_valid_q;
    assign Sched_Busy    = busy_q;
    assign Drop_Pulse    = drop_q;

endmodule

// File: tb/tb_tx_response_scheduler.sv
// Self-checking bench: vector table plus hand sequences, with a 10-cycle UART busy responder.
module tb_tx_response_scheduler;

    logic        CLK;
    logic        RST;
    logic        RdData_Valid;
    logic [7:0]  RdData;
    logic        ALU_OUT_Valid;
    logic [15:0] ALU_OUT;
    logic        TX_Busy;
    logic [7:0]  TX_P_Data;
    logic        TX_Data_Valid;
    logic        Sched_Busy;
    logic        Drop_Pulse;

    tx_response_scheduler #(.DATA_WIDTH(8), .ALU_WIDTH(16)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RdData_Valid  (RdData_Valid),
        .RdData        (RdData),
        .ALU_OUT_Valid (ALU_OUT_Valid),
        .ALU_OUT       (ALU_OUT),
        .TX_Busy       (TX_Busy),
        .TX_P_Data     (TX_P_Data),
        .TX_Data_Valid (TX_Data_Valid),
        .Sched_Busy    (Sched_Busy),
        .Drop_Pulse    (Drop_Pulse)
    );

    typedef struct {
        logic        rf_v;
        logic [7:0]  rf_d;
        int          rf_hold;
        logic        alu_v;
        logic [15:0] alu_d;
        int          alu_hold;
        int          n;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
    } vec_t;

    int         errors;
    int         checks;
    logic [7:0] exp_q[$];
    int         cap_cnt;
    int         busy_cnt;
    bit         resp_hold;
    int         drop_edges;
    int         drop_cycles;
    bit         drop_prev;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // UART TX model: accepts a request while idle, then stays busy for 10 cycles.
    initial begin
        TX_Busy  = 1'b0;
        busy_cnt = 0;
        cap_cnt  = 0;
        forever begin
            @(negedge CLK);
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) TX_Busy = 1'b0;
            end else if (!resp_hold && TX_Data_Valid && !TX_Busy) begin
                cap_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", TX_P_Data);
                end else begin
                    chk("tx_byte", 32'(TX_P_Data), 32'(exp_q.pop_front()));
                end
                TX_Busy  = 1'b1;
                busy_cnt = 10;
            end
        end
    end

    initial begin
        drop_edges  = 0;
        drop_cycles = 0;
        drop_prev   = 1'b0;
        forever begin
            @(negedge CLK);
            if (Drop_Pulse) drop_cycles++;
            if (Drop_Pulse && !drop_prev) drop_edges++;
            drop_prev = Drop_Pulse;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK); #1;
            if (!Sched_Busy && !TX_Busy && !TX_Data_Valid && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk({nm, "_idle"}, 32'(done), 32'd1);
    endtask

    task automatic wait_busy_phase(input string nm, input int cnt);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK); #1;
            if (TX_Busy && busy_cnt == cnt) begin
                done = 1'b1;
                break;
            end
        end
        chk({nm, "_busy_wait"}, 32'(done), 32'd1);
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        int hold;
        int d0;
        int c0;
        hold = (v.rf_hold > v.alu_hold) ? v.rf_hold : v.alu_hold;
        if (hold < 2) hold = 2;
        d0 = drop_edges;
        c0 = cap_cnt;
        if (v.n > 0) exp_q.push_back(v.b0);
        if (v.n > 1) exp_q.push_back(v.b1);
        if (v.n > 2) exp_q.push_back(v.b2);
        RdData        = v.rf_d;
        RdData_Valid  = v.rf_v;
        ALU_OUT       = v.alu_d;
        ALU_OUT_Valid = v.alu_v;
        for (int c = 0; c < hold; c++) begin
            @(negedge CLK); #1;
            if (c == 0) begin
                chk({nm, "_lat0_valid"}, 32'(TX_Data_Valid), 32'd0);
                chk({nm, "_lat0_busy"}, 32'(Sched_Busy), 32'd1);
            end
            if (c == 1) begin
                chk({nm, "_lat1_valid"}, 32'(TX_Data_Valid), 32'd1);
                chk({nm, "_lat1_data"}, 32'(TX_P_Data), 32'(v.b0));
            end
            if (c + 1 >= v.rf_hold) RdData_Valid = 1'b0;
            if (c + 1 >= v.alu_hold) ALU_OUT_Valid = 1'b0;
        end
        wait_idle(nm);
        chk({nm, "_nbytes"}, 32'(cap_cnt - c0), 32'(v.n));
        chk({nm, "_ndrops"}, 32'(drop_edges - d0), 32'd0);
    endtask

    initial begin
        vec_t vecs[4];
        vec_t v_post;
        int   d0;
        int   dc0;
        int   c0;
        bit   seen;

        errors    = 0;
        checks    = 0;
        resp_hold = 1'b0;

        vecs[0] = '{rf_v:1'b1, rf_d:8'h5A, rf_hold:1, alu_v:1'b0, alu_d:16'h0000, alu_hold:0,
                    n:1, b0:8'h5A, b1:8'h00, b2:8'h00};
        vecs[1] = '{rf_v:1'b0, rf_d:8'h00, rf_hold:0, alu_v:1'b1, alu_d:16'hBEEF, alu_hold:5,
                    n:2, b0:8'hEF, b1:8'hBE, b2:8'h00};
        vecs[2] = '{rf_v:1'b1, rf_d:8'h11, rf_hold:1, alu_v:1'b1, alu_d:16'h2233, alu_hold:1,
                    n:3, b0:8'h11, b1:8'h33, b2:8'h22};
        vecs[3] = '{rf_v:1'b1, rf_d:8'h11, rf_hold:1, alu_v:1'b1, alu_d:16'h2233, alu_hold:1,
                    n:3, b0:8'h33, b1:8'h22, b2:8'h11};
        v_post  = '{rf_v:1'b0, rf_d:8'h00, rf_hold:0, alu_v:1'b1, alu_d:16'h0102, alu_hold:1,
                    n:2, b0:8'h02, b1:8'h01, b2:8'h00};

        RST           = 1'b0;
        RdData_Valid  = 1'b0;
        RdData        = 8'h00;
        ALU_OUT_Valid = 1'b0;
        ALU_OUT       = 16'h0000;
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_valid", 32'(TX_Data_Valid), 32'd0);
        chk("rst_data", 32'(TX_P_Data), 32'd0);
        chk("rst_busy", 32'(Sched_Busy), 32'd0);
        chk("rst_drop", 32'(Drop_Pulse), 32'd0);
        RST = 1'b1;
        @(negedge CLK); #1;

        for (int i = 0; i < 4; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Second RF result while the first is still being transmitted is dropped.
        d0  = drop_edges;
        dc0 = drop_cycles;
        c0  = cap_cnt;
        exp_q.push_back(8'h66);
        RdData = 8'h66; RdData_Valid = 1'b1;
        @(negedge CLK); #1;
        RdData_Valid = 1'b0;
        wait_busy_phase("drop", 8);
        RdData = 8'h77; RdData_Valid = 1'b1;
        @(negedge CLK); #1;
        RdData_Valid = 1'b0;
        chk("drop_pulse_hi", 32'(Drop_Pulse), 32'd1);
        @(negedge CLK); #1;
        chk("drop_pulse_lo", 32'(Drop_Pulse), 32'd0);
        wait_idle("drop");
        chk("drop_edges", 32'(drop_edges - d0), 32'd1);
        chk("drop_width", 32'(drop_cycles - dc0), 32'd1);
        chk("drop_nbytes", 32'(cap_cnt - c0), 32'd1);

        // New RF edge lands on the same edge the RF slot clears.
        d0 = drop_edges;
        c0 = cap_cnt;
        exp_q.push_back(8'hA1);
        RdData = 8'hA1; RdData_Valid = 1'b1;
        @(negedge CLK); #1;
        RdData_Valid = 1'b0;
        wait_busy_phase("clrload", 1);
        @(negedge CLK); #1;
        exp_q.push_back(8'hB2);
        RdData = 8'hB2; RdData_Valid = 1'b1;
        @(negedge CLK); #1;
        RdData_Valid = 1'b0;
        wait_idle("clrload");
        chk("clrload_ndrops", 32'(drop_edges - d0), 32'd0);
        chk("clrload_nbytes", 32'(cap_cnt - c0), 32'd2);

        // Reset while the ALU upper byte is being requested.
        c0 = cap_cnt;
        exp_q.push_back(8'hDD);
        ALU_OUT = 16'hCCDD; ALU_OUT_Valid = 1'b1;
        @(negedge CLK); #1;
        ALU_OUT_Valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK); #1;
            if (cap_cnt == c0 + 1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rstmid_b0_seen", 32'(seen), 32'd1);
        resp_hold = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK); #1;
            if (TX_Data_Valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rstmid_b1_seen", 32'(seen), 32'd1);
        chk("rstmid_b1_data", 32'(TX_P_Data), 32'hCC);
        RST = 1'b0;
        #1;
        chk("rstmid_valid", 32'(TX_Data_Valid), 32'd0);
        chk("rstmid_data", 32'(TX_P_Data), 32'd0);
        chk("rstmid_busy", 32'(Sched_Busy), 32'd0);
        repeat (2) @(negedge CLK);
        #1;
        RST = 1'b1;
        resp_hold = 1'b0;
        chk("rstmid_queue", 32'(exp_q.size()), 32'd0);
        @(negedge CLK); #1;
        chk("rstmid_idle_valid", 32'(TX_Data_Valid), 32'd0);
        apply_vec(v_post, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
